// File: rtl/msp430_fetch_seq.sv
// MSP430 instruction fetch/decode sequencer: reset vector, opcode word and 0-2 extension words.
// Optional constant generator decode is enabled by defining MSP430_CONST_GEN_EN.
module msp430_fetch_seq #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] RST_VEC = 'hFFFE
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rdy,
    output logic              dec_valid,
    input  logic              dec_ack,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [15:0]       ir,
    output logic [15:0]       src_ext,
    output logic [15:0]       dst_ext,
    output logic [1:0]        fmt,
    output logic [1:0]        len,
    output logic              illegal,
    output logic              cg_valid,
    output logic [15:0]       cg_value
);

    typedef enum logic [2:0] {
        S_VEC,
        S_FETCH,
        S_SRC_EXT,
        S_DST_EXT,
        S_DECODED
    } state_t;

    typedef struct packed {
        logic [1:0]  fmt;
        logic        illegal;
        logic        src_x;
        logic        dst_x;
        logic        cg_v;
        logic [15:0] cg_val;
    } dec_t;

    function automatic dec_t f_decode(input logic [15:0] w);
        dec_t       d;
        logic [3:0] sreg;
        logic [1:0] as_f;
        logic       has_src;
        logic       is_cg;
        d       = '0;
        sreg    = w[11:8];
        as_f    = w[5:4];
        has_src = 1'b0;
        is_cg   = 1'b0;
        if (w[15:13] == 3'b001) begin
            d.fmt = 2'd3;
        end else if (w[15:10] == 6'b000100) begin
            if (w[9:7] == 3'd7) begin
                d.illegal = 1'b1;
            end else begin
                d.fmt   = 2'd2;
                sreg    = w[3:0];
                // RETI (subop 6) has no source operand at all
                has_src = (w[9:7] != 3'd6);
            end
        end else if (w[15:12] >= 4'd4) begin
            d.fmt   = 2'd1;
            has_src = 1'b1;
            d.dst_x = w[7];
        end else begin
            d.illegal = 1'b1;
        end
`ifdef MSP430_CONST_GEN_EN
        if (has_src && sreg == 4'd3) begin
            is_cg = 1'b1;
            case (as_f)
                2'b00:   d.cg_val = 16'h0000;
                2'b01:   d.cg_val = 16'h0001;
                2'b10:   d.cg_val = 16'h0002;
                default: d.cg_val = 16'hFFFF;
            endcase
        end else if (has_src && sreg == 4'd2 && as_f[1]) begin
            is_cg    = 1'b1;
            d.cg_val = as_f[0] ? 16'h0008 : 16'h0004;
        end
        d.cg_v = is_cg;
`endif
        d.src_x = has_src && (((as_f == 2'b01) && !is_cg) || ((as_f == 2'b11) && (sreg == 4'd0)));
        return d;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, r_instr_pc;
    logic [15:0]       r_ir, r_src_ext, r_dst_ext, r_cg_value;
    logic [1:0]        r_fmt, r_len;
    logic              r_illegal, r_cg_valid, r_need_dst;
    dec_t              w_dec;
    logic [ADDR_W-1:0] w_vec_pc, w_pc_inc, w_redirect;
    logic              w_unused;

    assign w_dec      = f_decode(mem_rdata);
    assign w_vec_pc   = ADDR_W'({mem_rdata[15:1], 1'b0});
    assign w_pc_inc   = r_pc + ADDR_W'(2);
    assign w_redirect = {pc_target[ADDR_W-1:1], 1'b0};
    assign w_unused   = pc_target[0];

    assign mem_rd    = !rst && (r_state != S_DECODED);
    assign mem_addr  = (r_state == S_VEC) ? {RST_VEC[ADDR_W-1:1], 1'b0} : r_pc;
    assign dec_valid = (r_state == S_DECODED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_VEC;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_VEC:     if (mem_rdy) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_rdy) begin
                    if (w_dec.src_x)      w_state_nxt = S_SRC_EXT;
                    else if (w_dec.dst_x) w_state_nxt = S_DST_EXT;
                    else                  w_state_nxt = S_DECODED;
                end
            end
            S_SRC_EXT: if (mem_rdy) w_state_nxt = r_need_dst ? S_DST_EXT : S_DECODED;
            S_DST_EXT: if (mem_rdy) w_state_nxt = S_DECODED;
            S_DECODED: if (dec_ack) w_state_nxt = S_FETCH;
            default:   w_state_nxt = S_VEC;
        endcase
    end

    // Decode fields are latched with the opcode word so they never follow mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_instr_pc <= '0;
            r_ir       <= '0;
            r_src_ext  <= '0;
            r_dst_ext  <= '0;
            r_fmt      <= 2'd0;
            r_len      <= 2'd1;
            r_illegal  <= 1'b0;
            r_cg_valid <= 1'b0;
            r_cg_value <= '0;
            r_need_dst <= 1'b0;
        end else begin
            case (r_state)
                S_VEC: if (mem_rdy) r_pc <= w_vec_pc;
                S_FETCH: begin
                    if (mem_rdy) begin
                        r_ir       <= mem_rdata;
                        r_instr_pc <= r_pc;
                        r_pc       <= w_pc_inc;
                        r_src_ext  <= '0;
                        r_dst_ext  <= '0;
                        r_fmt      <= w_dec.fmt;
                        r_illegal  <= w_dec.illegal;
                        r_cg_valid <= w_dec.cg_v;
                        r_cg_value <= w_dec.cg_val;
                        r_need_dst <= w_dec.dst_x;
                        r_len      <= 2'd1 + {1'b0, w_dec.src_x} + {1'b0, w_dec.dst_x};
                    end
                end
                S_SRC_EXT: begin
                    if (mem_rdy) begin
                        r_src_ext <= mem_rdata;
                        r_pc      <= w_pc_inc;
                    end
                end
                S_DST_EXT: begin
                    if (mem_rdy) begin
                        r_dst_ext <= mem_rdata;
                        r_pc      <= w_pc_inc;
                    end
                end
                S_DECODED: if (dec_ack && pc_load) r_pc <= w_redirect;
                default: ;
            endcase
        end
    end

    assign pc       = r_pc;
    assign instr_pc = r_instr_pc;
    assign ir       = r_ir;
    assign src_ext  = r_src_ext;
    assign dst_ext  = r_dst_ext;
    assign fmt      = r_fmt;
    assign len      = r_len;
    assign illegal  = r_illegal;
    assign cg_valid = r_cg_valid;
    assign cg_value = r_cg_value;

endmodule

// File: doc/msp430_fetch_seq.md
# msp430_fetch_seq

Parametrised instruction fetch/decode sequencer for the MSP430 core. It uses an explicit state machine to fetch the reset vector and then each instruction word, including its 0–2 extension words. Memory reads go through a ready handshake, so the block tolerates wait states. It presents the complete decoded instruction to the execute stage under a valid/ack handshake. It sits between program memory (ROM/MDB side) and the execute/register-file control logic.

## Interface
Parameters:
- ADDR_W, 16, program address width; legal range 16..20.
- RST_VEC, 'hFFFE, address of the reset vector word.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rd  out  1  read request to program memory.
- mem_addr  out  ADDR_W  read address; bit 0 always 0.
- mem_rdata  in  16  read data; valid when mem_rdy=1.
- mem_rdy  in  1  read complete this cycle.
- dec_valid  out  1  decoded instruction fields are valid.
- dec_ack  in  1  execute stage accepts the instruction.
- pc_load  in  1  redirect the next fetch; sampled only on an accept cycle.
- pc_target  in  ADDR_W  redirect address; bit 0 ignored.
- pc  out  ADDR_W  address of the next word to fetch.
- instr_pc  out  ADDR_W  address of the current instruction's first word.
- ir  out  16  instruction word.
- src_ext  out  16  source extension word; 0 if none.
- dst_ext  out  16  destination extension word; 0 if none.
- fmt  out  2  instruction format: 0 illegal, 1 format I, 2 format II, 3 jump.
- len  out  2  instruction length in words: 1..3.
- illegal  out  1  opcode is not a valid format I, format II or jump encoding.
- cg_valid  out  1  source operand comes from the constant generator.
- cg_value  out  16  constant generator value.

## Operation
- States: VEC, FETCH, SRC_EXT, DST_EXT, DECODED.
- VEC: mem_rd=1, mem_addr=RST_VEC. On mem_rdy, load pc with mem_rdata zero-extended (bit 0 cleared), then go to FETCH.
- FETCH: mem_rd=1, mem_addr=pc. On mem_rdy: ir←mem_rdata, instr_pc←pc, pc←pc+2, clear src_ext and dst_ext.
  - Next state is SRC_EXT if a source extension is needed, else DST_EXT if a destination extension is needed, else DECODED.
- SRC_EXT and DST_EXT: read at pc. On mem_rdy, capture into src_ext or dst_ext and do pc←pc+2.
  - SRC_EXT continues to DST_EXT if a destination extension is needed, else to DECODED.
  - DST_EXT continues to DECODED.
- Format decode from ir:
  - ir[15:13]=001 → jump.
  - ir[15:10]=000100 → format II; subops 0..6 are legal, subop 7 is illegal.
  - ir[15:12]≥4 → format I.
  - Anything else → illegal.
- Source field: format I uses sreg=ir[11:8] and As=ir[5:4]; format II uses sreg=ir[3:0] and As=ir[5:4].
- Source extension is needed when:
  - As=01, except constant-generator R3 (see Configuration); or
  - As=11 and sreg=0 (immediate).
  - RETI never needs one.
- Destination extension is needed for format I with Ad=ir[7]=1.
- Jumps and illegal opcodes have no extensions and len=1.
- len = 1 + (source ext) + (destination ext). It is valid from the cycle after the ir capture.
- DECODED: dec_valid=1. Hold all fields stable until dec_ack.
  - On dec_ack with pc_load=1: pc←{pc_target[ADDR_W-1:1],0}.
  - Go to FETCH.
- An accept (dec_ack=1) while dec_valid=0 is ignored, and pc_load is ignored on that cycle.
- mem_rd stays asserted with a stable mem_addr until mem_rdy. A mem_rdy while mem_rd=0 is ignored.
- pc wraps modulo 2^ADDR_W: pc=max-1 → 0.
- Reset values:
  - state=VEC; pc=0; instr_pc=0.
  - ir=0; src_ext=0; dst_ext=0.
  - fmt=0; len=1; illegal=0.
  - dec_valid=0; cg_valid=0; cg_value=0.
  - mem_rd=0 while rst is high.
- Reset mid-fetch or mid-handshake aborts immediately. Any pending read is discarded.

## Timing
- Zero-wait memory (mem_rdy high in the same cycle as mem_rd): an N-word instruction takes N fetch cycles, then dec_valid rises in cycle N+1.
- Each wait cycle (mem_rd=1, mem_rdy=0) adds exactly one cycle.
- Ack on the first dec_valid cycle: the next FETCH issues in the next cycle. Steady-state 1-word throughput is one instruction per 2 cycles.
- After rst deasserts, mem_rd=1 to RST_VEC in the first cycle.
- All decode outputs are registered; none combinationally depend on mem_rdata.

## Configuration
- MSP430_CONST_GEN_EN defined:
  - R3 with any As, and R2 with As=10 or 11, set cg_valid=1.
  - cg_value: R2/10=4, R2/11=8, R3/00=0, R3/01=1, R3/10=2, R3/11=FFFF.
  - R3 As=01 needs no extension word.
- MSP430_CONST_GEN_EN undefined:
  - cg_valid=0 and cg_value=0 always.
  - R2 and R3 decode as ordinary registers; R3 As=01 fetches a source extension word.
- R2 As=01 (absolute addressing) always fetches an extension word.

## Test plan
- Reset vector: RST_VEC word=F000 at zero wait.
  - → first fetch address F000.
  - → dec_valid in cycle 3 after rst deasserts.
  - → instr_pc=F000, pc=F002.
- Immediate plus indexed destination: ir=40B2 (MOV #imm, &abs), ext words 1234 and 0200.
  - → len=3, src_ext=1234, dst_ext=0200.
  - → pc advanced by 6.
  - → dec_valid 4 cycles after FETCH starts.
- Wait states: mem_rdy low for 2 cycles on each word of a 2-word instruction.
  - → mem_addr stable throughout each wait.
  - → dec_valid 7 cycles after FETCH starts.
- Back-pressure and redirect:
  - Hold dec_ack=0 for 5 cycles → fields stable, mem_rd=0.
  - Then ack with pc_load=1, pc_target=F101 → next fetch at F100.
- Constant generator: ir=4312 (MOV #1, R2).
  - With the macro → cg_valid=1, cg_value=0001, len=1.
  - Without the macro → len=2, src_ext captured.
- Reset mid-extension fetch: assert rst while in SRC_EXT.
  - → all outputs at reset values immediately.
  - → vector fetch restarts.
  - Also: illegal ir=0000 → illegal=1, fmt=0, len=1, dec_valid still asserted.
